pc_seq_unit: RTL and testbench
==============================

# pc_seq_unit

Parametrised program-counter unit for the MIPS datapath: holds the current fetch address and computes the next one each cycle. Supports sequential increment, conditional branch, absolute jump, call/return through an optional return-address stack (RAS), and stall. It sits at the head of the fetch stage, feeding the instruction memory address, with control inputs driven by the decode/ALU stages.

## Interface
- WIDTH, 32, address width in bits
- STEP, 4, sequential increment added to PC
- OFF_SHIFT, 2, left shift applied to branch offset
- RESET_VEC, 0, PC value after reset (WIDTH bits)
- RAS_DEPTH, 4, return-address stack entries (≥2, power of two)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  update enable; 0 = stall, all state held
- branch  in  1  conditional-branch instruction
- aluzero  in  1  branch condition from ALU
- branch_off  in  WIDTH  signed branch offset (instruction units)
- jump  in  1  absolute jump
- jump_target  in  WIDTH  absolute jump address
- call  in  1  jump-and-link: jump plus push return address
- ret  in  1  return: pop RAS into PC
- pc_out  out  WIDTH  current PC (registered)
- pc_plus  out  WIDTH  pc_out + STEP (combinational)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_err  out  1  one-cycle pulse on RAS underflow or call/ret conflict

## Operation
- Next-PC priority on each en=1 edge: ret > jump/call > taken branch (branch & aluzero) > sequential.
- Sequential: pc_out + STEP. Taken branch: pc_out + STEP + (branch_off << OFF_SHIFT), sign-extended, modulo 2^WIDTH (wrap, no overflow flag).
- jump or call: pc_out ← jump_target. call additionally pushes pc_plus.
- ret with RAS non-empty: pc_out ← top entry, count decrements.
- ret with RAS empty: sequential PC, ras_err pulses, count stays 0.
- call and ret in same cycle: ret wins, no push, ras_err pulses.
- call with RAS full: circular overwrite of oldest entry, count saturates at RAS_DEPTH, no error.
- en=0: pc_out, RAS contents, count held; ras_err forced 0; all control inputs ignored.

## Timing
- Reset (async assert, sync-safe deassert by upstream): pc_out=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_err=0; RAS entry contents don't-care.
- Latency: control sampled at edge N, new pc_out visible after edge N.
- pc_plus, ras_empty, ras_full derive from registered state; no input-to-output combinational path.
- ras_err registered: high for exactly the cycle after the offending edge.
- Reset mid-operation discards pending RAS entries; first post-reset cycle fetches RESET_VEC.

## Configuration
- PC_RAS_EN defined: RAS instantiated as above.
- PC_RAS_EN undefined: no storage; call behaves as jump, ret behaves as sequential; ras_empty tied 1, ras_full 0, ras_err 0.

## Structure
- Package pc_pkg: next-PC select enum (NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_RET), default STEP/OFF_SHIFT constants.
- Sub-module pc_ras: circular LIFO with push/pop/count, full/empty; instantiated only under PC_RAS_EN.

## Test plan
- Reset with RESET_VEC=0x100, then 3 cycles en=1 -> pc_out 0x100, 0x104, 0x108, 0x10C.
- pc_out=0x200, branch=1, aluzero=1, branch_off=-2 -> pc_out=0x1FC; same with aluzero=0 -> 0x204.
- call to 0x400 at pc 0x10, call to 0x800 at 0x400, ret, ret -> pc_out 0x400, 0x800, 0x404, 0x14, ras_empty=1.
- 5 calls with RAS_DEPTH=4 then 5 rets -> 4 correct returns (newest first), 5th ret sequential with ras_err pulse.
- en=0 for 3 cycles with jump=1 asserted -> pc_out unchanged; rst_n low mid-stall -> pc_out=RESET_VEC immediately.
- call and ret together with RAS top=0x40 -> pc_out=0x40, no push, ras_err=1 for one cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
// Next-PC source select plus default sequential step and branch-offset scaling.
package pc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_RET    = 2'd3
  } npc_sel_e;

  localparam int unsigned PC_DEF_STEP      = 4;
  localparam int unsigned PC_DEF_OFF_SHIFT = 2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop at a wrapping pointer, count saturates at DEPTH.
// A push when full overwrites the oldest entry; caller never asserts push and pop together.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] top_dat_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_idx;

  // ptr_q always points at the next free slot; the top lives one below it.
  assign top_idx   = ptr_q - PW'(1);
  assign top_dat_o = mem_q[top_idx];
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents are meaningless while count is zero, so no reset here.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage PC: sequential / branch / jump / call / return with stall on en=0.
// Return-address stack only present when PC_RAS_EN is defined; otherwise call=jump, ret=sequential.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       STEP      = PC_DEF_STEP,
  parameter int unsigned       OFF_SHIFT = PC_DEF_OFF_SHIFT,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             branch,
  input  logic             aluzero,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ras_err_q, ras_err_d;
  logic [WIDTH-1:0] ras_top;
  npc_sel_e         sel;

  assign pc_out  = pc_q;
  assign pc_plus = pc_q + WIDTH'(STEP);
  assign ras_err = ras_err_q;

`ifdef PC_RAS_EN
  logic ras_push, ras_pop;

  // A simultaneous call is dropped when ret is present: ret owns the stack this cycle.
  assign ras_push  = en && call && !ret;
  assign ras_pop   = en && ret && !ras_empty;
  assign ras_err_d = en && ret && (ras_empty || call);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_dat_i (pc_plus),
    .top_dat_o  (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err_d = 1'b0;
`endif

  // ret keeps top priority even when it degrades to sequential on an empty stack.
  always_comb begin
    sel = NPC_SEQ;
    if (ret) begin
      if (!ras_empty) sel = NPC_RET;
    end else if (jump || call) begin
      sel = NPC_JUMP;
    end else if (branch && aluzero) begin
      sel = NPC_BRANCH;
    end
  end

  always_comb begin
    pc_d = pc_plus;
    case (sel)
      NPC_BRANCH: pc_d = pc_plus + (branch_off << OFF_SHIFT);
      NPC_JUMP:   pc_d = jump_target;
      NPC_RET:    pc_d = ras_top;
      default:    pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VEC;
      ras_err_q <= 1'b0;
    end else begin
      if (en) pc_q <= pc_d;
      ras_err_q <= ras_err_d;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: queue-based reference model checked every cycle,
// plus literal PC/flag expectations at key points of each scenario.
module tb_pc_seq_unit;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, branch = 1'b0, aluzero = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] branch_off = '0, jump_target = '0;
  logic [31:0] pc_out, pc_plus;
  logic        ras_empty, ras_full, ras_err;

  int checks = 0;
  int failures = 0;

  pc_seq_unit #(
    .WIDTH     (W),
    .STEP      (4),
    .OFF_SHIFT (2),
    .RESET_VEC (RVEC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .branch      (branch),
    .aluzero     (aluzero),
    .branch_off  (branch_off),
    .jump        (jump),
    .jump_target (jump_target),
    .call        (call),
    .ret         (ret),
    .pc_out      (pc_out),
    .pc_plus     (pc_plus),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_err     (ras_err)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer, stack as a queue (newest at back).
  logic [31:0] pc_m = RVEC;
  logic [31:0] ras_m [$];
  logic        err_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nxt;
    if (!rst_n) begin
      pc_m  = RVEC;
      err_m = 1'b0;
      ras_m.delete();
    end else begin
      err_m = 1'b0;
      if (en) begin
        nxt = pc_m + 32'd4;
        if (ret) begin
          if (RAS_ON) begin
            err_m = (ras_m.size() == 0) || call;
            if (ras_m.size() > 0) nxt = ras_m.pop_back();
          end
        end else if (jump || call) begin
          if (RAS_ON && call) begin
            ras_m.push_back(pc_m + 32'd4);
            if (ras_m.size() > DEPTH) ras_m.delete(0);
          end
          nxt = jump_target;
        end else if (branch && aluzero) begin
          nxt = pc_m + 32'd4 + (branch_off << 2);
        end
        pc_m = nxt;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_pc", pc_out, pc_m);
    check("model_pc_plus", pc_plus, pc_m + 32'd4);
    check("model_empty", {31'd0, ras_empty}, {31'd0, ras_m.size() == 0});
    check("model_full", {31'd0, ras_full}, {31'd0, ras_m.size() == DEPTH});
    check("model_err", {31'd0, ras_err}, {31'd0, err_m});
  end

  task automatic step(input logic e, input logic br, input logic az, input logic [31:0] off,
                      input logic j, input logic [31:0] tgt, input logic c, input logic r);
    en = e; branch = br; aluzero = az; branch_off = off;
    jump = j; jump_target = tgt; call = c; ret = r;
    @(posedge clk);
    #1;
  endtask

  task automatic seq();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jmp(input logic [31:0] t);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic cal(input logic [31:0] t);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, t, 1'b1, 1'b0);
  endtask

  task automatic rtn();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_out, 32'h100);
    check("rst_empty", {31'd0, ras_empty}, 32'd1);
    check("rst_full", {31'd0, ras_full}, 32'd0);
    check("rst_err", {31'd0, ras_err}, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch
    seq(); check("seq1", pc_out, 32'h104);
    seq(); check("seq2", pc_out, 32'h108);
    seq(); check("seq3", pc_out, 32'h10C);

    // Branch taken / not taken with negative offset
    jmp(32'h200); check("jump200", pc_out, 32'h200);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0, 1'b0);
    check("br_taken", pc_out, 32'h1FC);
    jmp(32'h200);
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0, 1'b0);
    check("br_not_taken", pc_out, 32'h204);

    // Nested call / return
    jmp(32'h10);
    cal(32'h400); check("call1", pc_out, 32'h400);
    cal(32'h800); check("call2", pc_out, 32'h800);
    rtn(); check("ret1", pc_out, RAS_ON ? 32'h404 : 32'h804);
    rtn(); check("ret2", pc_out, RAS_ON ? 32'h14 : 32'h808);
    check("ret_empty", {31'd0, ras_empty}, 32'd1);

    // Overflow: five calls into a four-entry stack
    jmp(32'h1000);
    cal(32'h2000); cal(32'h3000); cal(32'h4000); cal(32'h5000); cal(32'h6000);
    check("ovf_pc", pc_out, 32'h6000);
    check("ovf_full", {31'd0, ras_full}, {31'd0, RAS_ON});
    check("ovf_err", {31'd0, ras_err}, 32'd0);
    rtn(); check("ovf_ret1", pc_out, RAS_ON ? 32'h5004 : 32'h6004);
    rtn(); check("ovf_ret2", pc_out, RAS_ON ? 32'h4004 : 32'h6008);
    rtn(); check("ovf_ret3", pc_out, RAS_ON ? 32'h3004 : 32'h600C);
    rtn(); check("ovf_ret4", pc_out, RAS_ON ? 32'h2004 : 32'h6010);
    rtn(); check("ovf_ret5", pc_out, RAS_ON ? 32'h2008 : 32'h6014);
    check("undf_err", {31'd0, ras_err}, {31'd0, RAS_ON});
    seq(); check("undf_err_clr", {31'd0, ras_err}, 32'd0);

    // Stall with jump asserted, then async reset while stalled
    jmp(32'h300); cal(32'h340);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD0, 1'b1, 1'b1);
    check("stall_pc", pc_out, 32'h340);
    check("stall_err", {31'd0, ras_err}, 32'd0);
    check("stall_empty", {31'd0, ras_empty}, {31'd0, !RAS_ON});
    #2 rst_n = 1'b0;
    #1 check("async_rst_pc", pc_out, 32'h100);
    check("async_rst_empty", {31'd0, ras_empty}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seq(); check("post_rst_seq", pc_out, 32'h104);

    // call and ret together with 0x40 on top of the stack
    jmp(32'h3C);
    cal(32'h500);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h900, 1'b1, 1'b1);
    check("conflict_pc", pc_out, RAS_ON ? 32'h40 : 32'h504);
    check("conflict_err", {31'd0, ras_err}, {31'd0, RAS_ON});
    check("conflict_empty", {31'd0, ras_empty}, 32'd1);
    seq(); check("conflict_err_clr", {31'd0, ras_err}, 32'd0);

    // Address wrap on sequential and branch paths
    jmp(32'hFFFF_FFFC);
    seq(); check("wrap_seq", pc_out, 32'h0);
    jmp(32'hFFFF_FFF0);
    step(1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_branch", pc_out, 32'h4);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
